// File: rtl/riscv_defines.sv
// Shared definitions for the platform event/interrupt unit: register map,
// bus FSM state type and small helper functions.
package riscv_defines;

    localparam logic [4:0] EVT_REG_MASK    = 5'h00;
    localparam logic [4:0] EVT_REG_PENDING = 5'h04;
    localparam logic [4:0] EVT_REG_SET     = 5'h08;
    localparam logic [4:0] EVT_REG_CLEAR   = 5'h0C;
    localparam logic [4:0] EVT_REG_TYPE    = 5'h10;
    localparam logic [4:0] EVT_REG_ID      = 5'h14;

    localparam logic [5:0] ID_NONE = 6'h20;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Lowest set bit index, ID_NONE when the vector is empty.
    function automatic logic [5:0] lowest_set(input logic [31:0] v);
        lowest_set = ID_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 6'(i);
        end
    endfunction

    function automatic logic [31:0] impl_mask(input int n);
        for (int i = 0; i < 32; i++) begin
            impl_mask[i] = (i < n);
        end
    endfunction

endpackage

// File: rtl/riscv_event_capture.sv
// Per-line event detect: level lines request every cycle they are high,
// edge lines request only on a 0->1 transition seen against a history flop.
module riscv_event_capture #(
    parameter int N_EVENTS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_EVENTS-1:0] event_i,
    input  logic [N_EVENTS-1:0] type_i,
    output logic [N_EVENTS-1:0] set_o
);

    logic [N_EVENTS-1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= event_i;
        end
    end

    assign set_o = (type_i & event_i & ~hist_q) | (~type_i & event_i);

endmodule

// File: rtl/riscv_irq_event_unit.sv
// Event-to-interrupt unit: pending/mask/type registers, set-beats-clear merge,
// core acknowledge retirement and a two-state register bus responder.
module riscv_irq_event_unit
    import riscv_defines::*;
#(
    parameter int N_EVENTS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_EVENTS-1:0] event_i,
    output logic [31:0]         irq_o,
    input  logic                irq_ack_i,
    input  logic [4:0]          irq_id_i,
    input  logic                bus_req_i,
    input  logic                bus_we_i,
    input  logic [ADDR_W-1:0]   bus_addr_i,
    input  logic [31:0]         bus_wdata_i,
    output logic                bus_gnt_o,
    output logic                bus_rvalid_o,
    output logic [31:0]         bus_rdata_o
);

    localparam logic [31:0] IMPL = impl_mask(N_EVENTS);

    bus_state_e          state_q, state_d;
    logic [31:0]         mask_q, mask_d;
    logic [31:0]         type_q, type_d;
    logic [31:0]         pending_q, pending_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [N_EVENTS-1:0] cap_set;
    logic [31:0]         evt_set, ack_clr, set_wr, clr_wr;
    logic [ADDR_W-1:0]   addr_w;
    logic                access;
    logic [5:0]          irq_id;
    logic                unused_addr_bits;

    riscv_event_capture #(.N_EVENTS(N_EVENTS)) u_capture (
        .clk     (clk),
        .rst_n   (rst_n),
        .event_i (event_i),
        .type_i  (type_q[N_EVENTS-1:0]),
        .set_o   (cap_set)
    );

    // Byte-lane bits of the address carry no meaning in a word-only window.
    assign addr_w           = {bus_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr_bits = ^bus_addr_i[1:0];

    assign access       = (state_q == BUS_IDLE) && bus_req_i;
    assign bus_gnt_o    = access;
    assign bus_rvalid_o = (state_q == BUS_RESP);
    assign bus_rdata_o  = rdata_q;
    assign irq_o        = pending_q & mask_q;
    assign irq_id       = lowest_set(irq_o);

    always_comb begin
        evt_set = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            evt_set[i] = cap_set[i];
        end
        ack_clr = '0;
        if (irq_ack_i && (32'(irq_id_i) < 32'(N_EVENTS))) begin
            ack_clr[irq_id_i] = 1'b1;
        end
    end

    always_comb begin
        mask_d  = mask_q;
        type_d  = type_q;
        set_wr  = '0;
        clr_wr  = '0;
        rdata_d = '0;
        state_d = (state_q == BUS_RESP) ? BUS_IDLE : (bus_req_i ? BUS_RESP : BUS_IDLE);
        if (access && bus_we_i) begin
            case (addr_w)
                ADDR_W'(EVT_REG_MASK):  mask_d = bus_wdata_i & IMPL;
                ADDR_W'(EVT_REG_TYPE):  type_d = bus_wdata_i & IMPL;
                ADDR_W'(EVT_REG_SET):   set_wr = bus_wdata_i;
                ADDR_W'(EVT_REG_CLEAR): clr_wr = bus_wdata_i;
                default: ;
            endcase
        end else if (access) begin
            case (addr_w)
                ADDR_W'(EVT_REG_MASK):    rdata_d = mask_q;
                ADDR_W'(EVT_REG_PENDING): rdata_d = pending_q;
                ADDR_W'(EVT_REG_TYPE):    rdata_d = type_q;
                ADDR_W'(EVT_REG_ID):      rdata_d = {26'b0, irq_id};
                default:                  rdata_d = '0;
            endcase
        end
        // Sets are applied after clears so a same-cycle event is never lost.
        pending_d = ((pending_q & ~(ack_clr | clr_wr)) | evt_set | set_wr) & IMPL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BUS_IDLE;
            mask_q    <= '0;
            type_q    <= '0;
            pending_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            type_q    <= type_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_riscv_irq_event_unit.sv
// Directed bench for the event/interrupt unit with 16 implemented lines, so the
// unimplemented upper lines and out-of-range acknowledges are exercised too.
module tb_riscv_irq_event_unit;

    localparam int N_EVENTS = 16;
    localparam int ADDR_W   = 5;

    localparam logic [4:0] A_MASK = 5'h00;
    localparam logic [4:0] A_PEND = 5'h04;
    localparam logic [4:0] A_SET  = 5'h08;
    localparam logic [4:0] A_CLR  = 5'h0C;
    localparam logic [4:0] A_TYPE = 5'h10;
    localparam logic [4:0] A_ID   = 5'h14;

    logic                clk;
    logic                rst_n;
    logic [N_EVENTS-1:0] event_i;
    logic [31:0]         irq_o;
    logic                irq_ack_i;
    logic [4:0]          irq_id_i;
    logic                bus_req_i;
    logic                bus_we_i;
    logic [ADDR_W-1:0]   bus_addr_i;
    logic [31:0]         bus_wdata_i;
    logic                bus_gnt_o;
    logic                bus_rvalid_o;
    logic [31:0]         bus_rdata_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd;

    riscv_irq_event_unit #(.N_EVENTS(N_EVENTS), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_i      (event_i),
        .irq_o        (irq_o),
        .irq_ack_i    (irq_ack_i),
        .irq_id_i     (irq_id_i),
        .bus_req_i    (bus_req_i),
        .bus_we_i     (bus_we_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_gnt_o    (bus_gnt_o),
        .bus_rvalid_o (bus_rvalid_o),
        .bus_rdata_o  (bus_rdata_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks: one bus access, returning when the response has completed
    task automatic bus_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                              output logic [31:0] data);
        bus_req_i   = 1'b1;
        bus_we_i    = we;
        bus_addr_i  = addr;
        bus_wdata_i = wdata;
        #1;
        check("gnt", {31'b0, bus_gnt_o}, 32'd1);
        @(posedge clk);
        #1;
        bus_req_i = 1'b0;
        bus_we_i  = 1'b0;
        check("rvalid_hi", {31'b0, bus_rvalid_o}, 32'd1);
        data = bus_rdata_o;
        tick();
        check("rvalid_lo", {31'b0, bus_rvalid_o}, 32'd0);
    endtask

    task automatic bus_wr(input logic [4:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        bus_access(1'b1, addr, wdata, d);
        check("wr_rdata", d, 32'd0);
    endtask

    task automatic bus_rd(input logic [4:0] addr, output logic [31:0] data);
        bus_access(1'b0, addr, 32'd0, data);
    endtask

    initial begin
        rst_n       = 1'b0;
        event_i     = '0;
        irq_ack_i   = 1'b0;
        irq_id_i    = '0;
        bus_req_i   = 1'b0;
        bus_we_i    = 1'b0;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
        repeat (2) tick();
        check("rst_irq", irq_o, 32'd0);
        check("rst_gnt", {31'b0, bus_gnt_o}, 32'd0);
        check("rst_rvalid", {31'b0, bus_rvalid_o}, 32'd0);
        check("rst_rdata", bus_rdata_o, 32'd0);
        rst_n = 1'b1;
        tick();

        bus_rd(A_MASK, rd); check("rst_mask", rd, 32'd0);
        bus_rd(A_PEND, rd); check("rst_pend", rd, 32'd0);
        bus_rd(A_TYPE, rd); check("rst_type", rd, 32'd0);
        bus_rd(A_ID, rd);   check("rst_id", rd, 32'h20);

        // edge-triggered line 3
        bus_wr(A_TYPE, 32'h8);
        bus_wr(A_MASK, 32'h8);
        event_i = 16'h0008;
        tick();
        check("edge_pulse_irq", irq_o, 32'h8);
        event_i = '0;
        bus_wr(A_CLR, 32'h8);
        check("edge_clr_irq", irq_o, 32'h0);
        event_i = 16'h0008;
        tick();
        check("edge_hold_irq", irq_o, 32'h8);
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd3;
        tick();
        irq_ack_i = 1'b0;
        check("edge_ack_irq", irq_o, 32'h0);
        repeat (8) tick();
        check("edge_held_no_repend", irq_o, 32'h0);

        // ack and new edge on the same line in the same cycle
        event_i = '0;
        tick();
        event_i = 16'h0008;
        tick();
        event_i = '0;
        tick();
        check("race_setup", irq_o, 32'h8);
        event_i   = 16'h0008;
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd3;
        tick();
        irq_ack_i = 1'b0;
        event_i   = '0;
        check("race_pend_kept", irq_o, 32'h8);
        bus_wr(A_CLR, 32'h8);
        check("race_cleanup", irq_o, 32'h0);

        // priority ID and masking
        bus_wr(A_TYPE, 32'h0);
        bus_wr(A_SET, 32'h0000_0A00);
        bus_wr(A_MASK, 32'hFFFF_FFFF);
        bus_rd(A_MASK, rd);  check("mask_impl_bits", rd, 32'h0000_FFFF);
        check("prio_irq", irq_o, 32'h0000_0A00);
        bus_rd(A_ID, rd);    check("prio_id", rd, 32'd9);
        bus_wr(A_MASK, 32'h0);
        check("masked_irq", irq_o, 32'h0);
        bus_rd(A_ID, rd);    check("masked_id", rd, 32'h20);
        bus_rd(A_PEND, rd);  check("masked_pend_kept", rd, 32'h0000_0A00);

        // set/read, unmapped, misaligned, unimplemented lines, ack range
        bus_wr(A_CLR, 32'hFFFF_FFFF);
        bus_wr(A_SET, 32'h5);
        bus_rd(A_PEND, rd);  check("set_read", rd, 32'h5);
        bus_rd(5'h1C, rd);   check("unmapped_rd", rd, 32'h0);
        bus_wr(5'h1C, 32'hFFFF_FFFF);
        bus_rd(5'h06, rd);   check("misaligned_pend", rd, 32'h5);
        bus_wr(A_SET, 32'hFFFF_FFFF);
        bus_rd(A_PEND, rd);  check("pend_impl_bits", rd, 32'h0000_FFFF);
        irq_ack_i = 1'b1;
        irq_id_i  = 5'd20;
        tick();
        irq_id_i  = 5'd0;
        tick();
        irq_ack_i = 1'b0;
        bus_rd(A_PEND, rd);  check("ack_range", rd, 32'h0000_FFFE);
        bus_wr(A_CLR, 32'hFFFF_FFFF);

        // back-to-back requests: one access every two cycles
        bus_req_i  = 1'b1;
        bus_we_i   = 1'b0;
        bus_addr_i = A_PEND;
        #1;
        check("b2b_gnt0", {31'b0, bus_gnt_o}, 32'd1);
        tick();
        check("b2b_gnt1", {31'b0, bus_gnt_o}, 32'd0);
        check("b2b_rv1", {31'b0, bus_rvalid_o}, 32'd1);
        tick();
        check("b2b_gnt2", {31'b0, bus_gnt_o}, 32'd1);
        check("b2b_rv2", {31'b0, bus_rvalid_o}, 32'd0);
        tick();
        check("b2b_rv3", {31'b0, bus_rvalid_o}, 32'd1);
        bus_req_i = 1'b0;
        tick();
        check("b2b_rv4", {31'b0, bus_rvalid_o}, 32'd0);

        // CLEAR write against a held level event on line 0
        event_i = 16'h0001;
        bus_wr(A_CLR, 32'h1);
        event_i = '0;
        bus_rd(A_PEND, rd);  check("set_beats_clr", rd, 32'h1);

        // reset in the response cycle of a read
        bus_wr(A_MASK, 32'hF);
        check("pre_rst_irq", irq_o, 32'h1);
        bus_req_i  = 1'b1;
        bus_we_i   = 1'b0;
        bus_addr_i = A_PEND;
        tick();
        bus_req_i = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'b0, bus_rvalid_o}, 32'd0);
        check("mid_rst_irq", irq_o, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rvalid", {31'b0, bus_rvalid_o}, 32'd0);
        bus_rd(A_MASK, rd);  check("post_rst_mask", rd, 32'h0);
        bus_rd(A_PEND, rd);  check("post_rst_pend", rd, 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
